ps2_key_event_rx: RTL and testbench

Parametrised PS/2 keyboard receiver that replaces the raw shift-register keyboard path feeding the processor's pixel/key input. It samples the keyboard clock and data lines, deframes 11-bit PS/2 frames and folds E0/F0 prefixes into single key events. Typematic repeats are filtered so each physical press yields one make event. Events are buffered in a FIFO with a valid/ready pop port, so the processor or VGA-side logic can consume them at its own rate.

---
 rtl/ps2_key_event_rx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
// ps2_key_event_rx: PS/2 keyboard receiver producing filtered key events.
// Samples the PS/2 clock/data lines, deframes 11-bit frames, folds E0/F0
// prefixes into {break, extended, code} events, suppresses typematic
// repeats and queues events in a FIFO with a valid/ready pop port.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames whose
// data+parity bits are not odd; otherwise the parity bit is ignored.
module ps2_key_event_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          iCLK,
  input  logic                          iRST_n,
  input  logic                          iPS2_CLK,
  input  logic                          iPS2_DAT,
  output logic [9:0]                    oEVT_DATA,
  output logic                          oEVT_VALID,
  input  logic                          iEVT_READY,
  output logic [$clog2(FIFO_DEPTH):0]   oFIFO_COUNT,
  output logic                          oOVERFLOW,
  input  logic                          iOVF_CLR,
  output logic                          oFRAME_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------
  // Input synchronisation and falling-edge detection
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] dat_sync_reg;
  logic                   clk_prev_reg;
  logic                   ps2_clk_s;
  logic                   ps2_dat_s;
  logic                   ps2_fall;

  // Bring the asynchronous PS/2 lines into the iCLK domain; idle lines are high.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync_reg <= '1;
      dat_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], iPS2_CLK};
      dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], iPS2_DAT};
      clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign ps2_clk_s = clk_sync_reg[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_reg[SYNC_STAGES-1];
  assign ps2_fall  = clk_prev_reg & ~ps2_clk_s;

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  state_t         state_reg, state_next;
  logic [2:0]     bit_cnt_reg;
  logic [7:0]     shift_reg;
  logic [TW-1:0]  timeout_cnt_reg;
  logic           timeout;
  logic           parity_ok;
  logic           frame_err_next, frame_err_reg;
  logic           byte_ok_next, byte_strobe_reg;
  logic [7:0]     byte_reg;

  // A frame in progress is abandoned after TIMEOUT_CYCLES without an edge.
  assign timeout = (state_reg != S_IDLE) && !ps2_fall && (timeout_cnt_reg == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
  logic parity_reg;
  assign parity_ok = ^{parity_reg, shift_reg};
`else
  assign parity_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic: advance one step per PS/2 falling edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (ps2_fall && !ps2_dat_s) state_next = S_DATA;
      S_DATA: begin
        if (ps2_fall && bit_cnt_reg == 3'd7) state_next = S_PARITY;
        else if (timeout)                    state_next = S_IDLE;
      end
      S_PARITY: begin
        if (ps2_fall)     state_next = S_STOP;
        else if (timeout) state_next = S_IDLE;
      end
      S_STOP:   if (ps2_fall || timeout) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output logic: byte acceptance and frame-error detection.
  always_comb begin
    frame_err_next = 1'b0;
    byte_ok_next   = 1'b0;
    if (timeout) begin
      frame_err_next = 1'b1;
    end else if (ps2_fall) begin
      if (state_reg == S_IDLE && ps2_dat_s) begin
        frame_err_next = 1'b1;
      end else if (state_reg == S_STOP) begin
        if (ps2_dat_s && parity_ok) byte_ok_next   = 1'b1;
        else                        frame_err_next = 1'b1;
      end
    end
  end

  // Frame datapath: shift data bits LSB first, count bits, run the timeout.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bit_cnt_reg     <= 3'd0;
      shift_reg       <= 8'd0;
      timeout_cnt_reg <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_reg      <= 1'b0;
`endif
    end else begin
      if (state_reg == S_IDLE || ps2_fall) timeout_cnt_reg <= '0;
      else                                 timeout_cnt_reg <= timeout_cnt_reg + TO_ONE;
      if (ps2_fall) begin
        case (state_reg)
          S_IDLE: bit_cnt_reg <= 3'd0;
          S_DATA: begin
            shift_reg   <= {ps2_dat_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
`ifdef PS2_PARITY_CHECK_EN
          S_PARITY: parity_reg <= ps2_dat_s;
`endif
          default: ;
        endcase
      end
    end
  end

  // Register the accepted byte and the error pulse for the next stage.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      frame_err_reg   <= 1'b0;
      byte_strobe_reg <= 1'b0;
      byte_reg        <= 8'd0;
    end else begin
      frame_err_reg   <= frame_err_next;
      byte_strobe_reg <= byte_ok_next;
      if (byte_ok_next) byte_reg <= shift_reg;
    end
  end

  assign oFRAME_ERR = frame_err_reg;

  // ---------------------------------------------------------------
  // Prefix decoder and typematic repeat filter
  // ---------------------------------------------------------------
  logic       ext_pend_reg, brk_pend_reg;
  logic [8:0] last_make_reg;
  logic       held_valid_reg;
  logic       is_e0, is_f0, is_junk;
  logic       evt_form;
  logic [8:0] evt_key;
  logic       key_match;
  logic       push;
  logic [9:0] push_data;

  assign is_e0     = (byte_reg == 8'hE0);
  assign is_f0     = (byte_reg == 8'hF0);
  assign is_junk   = (byte_reg == 8'hAA) || (byte_reg == 8'hFA) || (byte_reg == 8'hEE) ||
                     (byte_reg == 8'hFE) || (byte_reg == 8'h00) || (byte_reg == 8'hFF);
  assign evt_form  = byte_strobe_reg && !is_e0 && !is_f0 && !is_junk;
  assign evt_key   = {ext_pend_reg, byte_reg};
  assign key_match = held_valid_reg && (evt_key == last_make_reg);
  assign push      = evt_form && (brk_pend_reg || !key_match);
  assign push_data = {brk_pend_reg, ext_pend_reg, byte_reg};

  // Track pending prefixes and the currently held key.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ext_pend_reg   <= 1'b0;
      brk_pend_reg   <= 1'b0;
      last_make_reg  <= 9'd0;
      held_valid_reg <= 1'b0;
    end else if (byte_strobe_reg) begin
      if (is_e0) begin
        ext_pend_reg <= 1'b1;
      end else if (is_f0) begin
        brk_pend_reg <= 1'b1;
      end else begin
        ext_pend_reg <= 1'b0;
        brk_pend_reg <= 1'b0;
      end
      if (evt_form) begin
        if (!brk_pend_reg) begin
          if (!key_match) begin
            last_make_reg  <= evt_key;
            held_valid_reg <= 1'b1;
          end
        end else if (key_match) begin
          held_valid_reg <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;
  logic        ovf_set;
  logic        ovf_reg;

  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full  = (fifo_count == DEPTH_L);
  assign oEVT_VALID = (fifo_count != '0);
  assign pop        = oEVT_VALID && iEVT_READY;
  assign push_ok    = push && (!fifo_full || pop);
  assign ovf_set    = push && fifo_full && !pop;

  // Storage write; contents need no reset because the head is gated by valid.
  always_ff @(posedge iCLK) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  // Pointer update and sticky overflow flag (set beats clear).
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (ovf_set)       ovf_reg <= 1'b1;
      else if (iOVF_CLR) ovf_reg <= 1'b0;
    end
  end

  assign oEVT_DATA   = oEVT_VALID ? mem[rd_ptr_reg[AW-1:0]] : 10'd0;
  assign oFIFO_COUNT = fifo_count;
  assign oOVERFLOW   = ovf_reg;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Testbench for ps2_key_event_rx: table-driven key sequences plus
// hand-written sequences for overflow, errors, timeout, reset and latency.
module tb_ps2_key_event_rx;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int TO    = 200;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     ps2_clk = 1'b1;
  logic                     ps2_dat = 1'b1;
  logic                     evt_ready = 1'b0;
  logic                     ovf_clr = 1'b0;
  logic [9:0]               evt_data;
  logic                     evt_valid;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic                     frame_err;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;

  ps2_key_event_rx #(
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iPS2_CLK(ps2_clk), .iPS2_DAT(ps2_dat),
    .oEVT_DATA(evt_data), .oEVT_VALID(evt_valid), .iEVT_READY(evt_ready),
    .oFIFO_COUNT(fifo_count), .oOVERFLOW(overflow), .iOVF_CLR(ovf_clr),
    .oFRAME_ERR(frame_err)
  );

  always #5 clk = ~clk;

  // Count every cycle the error line is high; a one-cycle pulse adds exactly 1.
  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0]  nb;   // number of frames
    logic [63:0] b;    // frames, first byte in bits 63:56
    logic [2:0]  ne;   // number of expected events
    logic [39:0] e;    // events, first in bits 39:30
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One PS/2 bit: data set while clock high, then a falling and rising edge.
  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_flip);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic pop_expect(input string name, input logic [9:0] e);
    int n;
    n = 0;
    while (evt_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " valid"}, 32'(evt_valid), 32'd1);
    chk({name, " data"}, 32'(evt_data), 32'(e));
    evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
  endtask

  initial begin
    int e0;
    // --- reset state ---
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(evt_valid), 32'd0);
    chk("reset count", 32'(fifo_count), 32'd0);
    chk("reset data", 32'(evt_data), 32'd0);
    chk("reset ovf", 32'(overflow), 32'd0);
    chk("reset ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // --- vector table ---
    vecs[0] = '{nb: 4'd3, b: 64'h1CF01C00_00000000, ne: 3'd2, e: {10'h01C, 10'h21C, 10'h000, 10'h000}};
    vecs[1] = '{nb: 4'd4, b: 64'hE0F07575_00000000, ne: 3'd2, e: {10'h375, 10'h075, 10'h000, 10'h000}};
    vecs[2] = '{nb: 4'd8, b: 64'h1C1C1C1C_1CF01C1C, ne: 3'd3, e: {10'h01C, 10'h21C, 10'h01C, 10'h000}};
    vecs[3] = '{nb: 4'd5, b: 64'hE014E0F0_14000000, ne: 3'd2, e: {10'h114, 10'h314, 10'h000, 10'h000}};
    vecs[4] = '{nb: 4'd5, b: 64'hE0AA1CF0_1C000000, ne: 3'd2, e: {10'h01C, 10'h21C, 10'h000, 10'h000}};
    vecs[5] = '{nb: 4'd5, b: 64'hF0FA32F0_32000000, ne: 3'd2, e: {10'h032, 10'h232, 10'h000, 10'h000}};
    vecs[6] = '{nb: 4'd7, b: 64'hE000F0FF_21F02100, ne: 3'd2, e: {10'h021, 10'h221, 10'h000, 10'h000}};

    for (int v = 0; v < 7; v++) begin
      e0 = err_cnt;
      for (int i = 0; i < int'(vecs[v].nb); i++) send_frame(vecs[v].b[63-8*i -: 8], 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk($sformatf("vec%0d count", v), 32'(fifo_count), 32'(vecs[v].ne));
      for (int j = 0; j < int'(vecs[v].ne); j++)
        pop_expect($sformatf("vec%0d ev%0d", v, j), vecs[v].e[39-10*j -: 10]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d empty", v), 32'(evt_valid), 32'd0);
      chk($sformatf("vec%0d ferr", v), 32'(err_cnt - e0), 32'd0);
      $display("vector %0d: %0d frames, %0d events checked", v, vecs[v].nb, vecs[v].ne);
    end

    // --- overflow: five distinct makes into a 4-deep FIFO ---
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    send_frame(8'h21, 1'b0, 1'b1);
    send_frame(8'h23, 1'b0, 1'b1);
    send_frame(8'h24, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf count", 32'(fifo_count), 32'd4);
    chk("ovf flag", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    chk("ovf clear", 32'(overflow), 32'd0);
    chk("ovf count kept", 32'(fifo_count), 32'd4);
    pop_expect("ovf ev0", 10'h01C);
    pop_expect("ovf ev1", 10'h032);
    pop_expect("ovf ev2", 10'h021);
    pop_expect("ovf ev3", 10'h023);
    @(posedge clk);
    #1;
    chk("ovf empty", 32'(evt_valid), 32'd0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h24, 1'b0, 1'b1);
    pop_expect("ovf brk24", 10'h224);
    $display("overflow sequence done");

    // --- wrong parity on 1C ---
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
`ifdef PS2_PARITY_CHECK_EN
    chk("parity ferr", 32'(err_cnt - e0), 32'd1);
    chk("parity no event", 32'(evt_valid), 32'd0);
`else
    chk("parity ferr", 32'(err_cnt - e0), 32'd0);
    pop_expect("parity ignored", 10'h01C);
`endif
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_expect("parity brk", 10'h21C);
    $display("parity sequence done");

    // --- bad stop bit ---
    e0 = err_cnt;
    send_frame(8'h32, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("stop ferr", 32'(err_cnt - e0), 32'd1);
    chk("stop no event", 32'(evt_valid), 32'd0);
    $display("bad stop sequence done");

    // --- timeout after 4 data bits ---
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (TO + 50) @(posedge clk);
    #1;
    chk("timeout ferr", 32'(err_cnt - e0), 32'd1);
    chk("timeout no event", 32'(evt_valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_expect("timeout next", 10'h01C);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_expect("timeout brk", 10'h21C);
    $display("timeout sequence done");

    // --- bad start bit while idle ---
    e0 = err_cnt;
    ps2_bit(1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("start ferr", 32'(err_cnt - e0), 32'd1);
    chk("start no event", 32'(evt_valid), 32'd0);
    $display("bad start sequence done");

    // --- reset mid-frame with an event already queued ---
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("pre-reset count", 32'(fifo_count), 32'd1);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'(8'h1C >> i));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst valid", 32'(evt_valid), 32'd0);
    chk("midrst count", 32'(fifo_count), 32'd0);
    chk("midrst data", 32'(evt_data), 32'd0);
    chk("midrst ovf", 32'(overflow), 32'd0);
    chk("midrst ferr", 32'(frame_err), 32'd0);
    ps2_dat = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // Clean 1C frame after reset, with latency measured from the stop edge.
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(1'(8'h1C >> i));
    ps2_bit(1'b0);
    ps2_dat = 1'b1;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    #1;
    chk("latency early", 32'(evt_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency on time", 32'(evt_valid), 32'd1);
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst count", 32'(fifo_count), 32'd1);
    pop_expect("postrst ev", 10'h01C);
    repeat (5) @(posedge clk);
    #1;
    chk("postrst empty", 32'(evt_valid), 32'd0);
    chk("postrst ferr", 32'(err_cnt - e0), 32'd0);
    $display("reset sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
